// File: rtl/ps2_pkg.sv
// Shared constants, key state encoding and event word layout for the PS/2 key encoder.
package ps2_pkg;

   localparam logic [7:0] PS2_EXT    = 8'hE0;
   localparam logic [7:0] PS2_BRK    = 8'hF0;
   localparam logic [7:0] PS2_PAUSE  = 8'hE1;
   localparam logic [2:0] PAUSE_SKIP = 3'd7;

   localparam int unsigned FRAME_LEN = 11;
   localparam int unsigned BIT_CNT_W = 4;
   localparam int unsigned CODE_W    = 8;
   localparam int unsigned KEY_W     = 11;
   localparam int unsigned TO_W      = 16;
   localparam int unsigned ERR_W     = 8;

   typedef enum logic [2:0] {
      IDLE,
      EXT,
      BRK,
      EXT_BRK,
      SKIP
   } key_state_t;

   // Layout of the toggle-strobed ps2_key word
   typedef struct packed {
      logic              toggle;
      logic              pressed;
      logic              ext;
      logic [CODE_W-1:0] code;
   } ps2_key_t;

   // Status/acknowledge bytes that never form part of a key event
   function automatic logic is_nonkey(input logic [CODE_W-1:0] code);
      case (code)
         8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: return 1'b1;
         default:                                               return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/ps2_key_encoder_rx.sv
// PS/2 frame receiver: line synchronizers, clock glitch filter, 11-bit shifter,
// start/parity/stop validation and mid-frame timeout.
module ps2_rx_frame
   import ps2_pkg::*;
#(
   parameter int unsigned     FILTER_LEN = 8,
   parameter logic [TO_W-1:0] TIMEOUT    = 16'd6000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ps2_clk,
   input  logic              ps2_data,
   output logic              byte_valid,
   output logic [CODE_W-1:0] byte_data,
   output logic              frame_err
);

   localparam int unsigned          FLT_W    = $clog2(FILTER_LEN + 1);
   localparam logic [FLT_W-1:0]     FLT_LAST = FLT_W'(FILTER_LEN - 1);
   localparam logic [BIT_CNT_W-1:0] LAST_DATA_IDX = BIT_CNT_W'(CODE_W);
   localparam logic [BIT_CNT_W-1:0] PAR_IDX  = BIT_CNT_W'(FRAME_LEN - 2);
   localparam logic [BIT_CNT_W-1:0] STOP_IDX = BIT_CNT_W'(FRAME_LEN - 1);

   logic [1:0]           clk_sync_q;
   logic [1:0]           data_sync_q;
   logic                 clk_s;
   logic                 data_s;
   logic                 clk_filt;
   logic [FLT_W-1:0]     flt_cnt;
   logic                 fall_c;
   logic [BIT_CNT_W-1:0] bit_cnt;
   logic [CODE_W-1:0]    shift_q;
   logic                 parity_q;
   logic [TO_W-1:0]      to_cnt;

   // Two-flop synchronizers; lines idle high
   always_ff @(posedge clk) begin
      if (reset) begin
         clk_sync_q  <= 2'b11;
         data_sync_q <= 2'b11;
      end else begin
         clk_sync_q  <= {clk_sync_q[0], ps2_clk};
         data_sync_q <= {data_sync_q[0], ps2_data};
      end
   end

   assign clk_s  = clk_sync_q[1];
   assign data_s = data_sync_q[1];

   // Accept a clock level only after FILTER_LEN consecutive differing samples
   always_ff @(posedge clk) begin
      if (reset) begin
         clk_filt <= 1'b1;
         flt_cnt  <= '0;
      end else if (clk_s == clk_filt) begin
         flt_cnt <= '0;
      end else if (flt_cnt == FLT_LAST) begin
         clk_filt <= clk_s;
         flt_cnt  <= '0;
      end else begin
         flt_cnt <= flt_cnt + FLT_W'(1);
      end
   end

   assign fall_c = clk_filt && !clk_s && (flt_cnt == FLT_LAST);

   // Bit shifter with validation; a falling edge always beats a timeout
   always_ff @(posedge clk) begin
      if (reset) begin
         bit_cnt    <= '0;
         shift_q    <= '0;
         parity_q   <= 1'b0;
         to_cnt     <= TIMEOUT;
         byte_valid <= 1'b0;
         byte_data  <= '0;
         frame_err  <= 1'b0;
      end else begin
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
         if (fall_c) begin
            to_cnt <= TIMEOUT;
            if (bit_cnt == '0) begin
               if (data_s) frame_err <= 1'b1;
               else        bit_cnt   <= BIT_CNT_W'(1);
            end else if (bit_cnt <= LAST_DATA_IDX) begin
               shift_q <= {data_s, shift_q[CODE_W-1:1]};
               bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            end else if (bit_cnt == PAR_IDX) begin
               parity_q <= data_s;
               bit_cnt  <= STOP_IDX;
            end else begin
               bit_cnt <= '0;
               if (data_s && (^{shift_q, parity_q})) begin
                  byte_valid <= 1'b1;
                  byte_data  <= shift_q;
               end else begin
                  frame_err <= 1'b1;
               end
            end
         end else if (bit_cnt != '0) begin
            if (to_cnt <= TO_W'(1)) begin
               frame_err <= 1'b1;
               bit_cnt   <= '0;
               to_cnt    <= TIMEOUT;
            end else begin
               to_cnt <= to_cnt - TO_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/ps2_key_encoder.sv
// PS/2 keyboard to toggle-strobed ps2_key event word. Optional typematic repeat
// suppression is enabled by defining PS2_TYPEMATIC_FILTER_EN.
module ps2_key_encoder
   import ps2_pkg::*;
#(
   parameter int unsigned     FILTER_LEN = 8,
   parameter logic [TO_W-1:0] TIMEOUT    = 16'd6000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ps2_clk,
   input  logic             ps2_data,
   output logic [KEY_W-1:0] ps2_key,
   output logic             frame_err,
   output logic [ERR_W-1:0] err_cnt
);

   logic              byte_valid;
   logic [CODE_W-1:0] byte_data;
   key_state_t        state;
   logic [2:0]        skip_cnt;
   ps2_key_t          key_q;
   logic              ev_req_c;
   logic              ev_pressed_c;
   logic              ev_ext_c;
   logic              suppress_c;

   ps2_rx_frame #(
      .FILTER_LEN (FILTER_LEN),
      .TIMEOUT    (TIMEOUT)
   ) u_rx (
      .clk        (clk),
      .reset      (reset),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .frame_err  (frame_err)
   );

   // Which bytes complete a key event, and with what press/extended flags
   always_comb begin
      ev_req_c     = 1'b0;
      ev_pressed_c = 1'b1;
      ev_ext_c     = 1'b0;
      if (byte_valid && (state != SKIP) && !is_nonkey(byte_data)) begin
         case (state)
            IDLE: begin
               ev_req_c = (byte_data != PS2_EXT) && (byte_data != PS2_BRK) &&
                          (byte_data != PS2_PAUSE);
            end
            EXT: begin
               ev_req_c = (byte_data != PS2_EXT) && (byte_data != PS2_BRK);
               ev_ext_c = 1'b1;
            end
            BRK: begin
               ev_req_c     = 1'b1;
               ev_pressed_c = 1'b0;
            end
            EXT_BRK: begin
               ev_req_c     = 1'b1;
               ev_pressed_c = 1'b0;
               ev_ext_c     = 1'b1;
            end
            default: ev_req_c = 1'b0;
         endcase
      end
   end

   // Prefix / break / pause-skip state machine
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         skip_cnt <= '0;
      end else if (byte_valid) begin
         if (state == SKIP) begin
            skip_cnt <= skip_cnt - 3'd1;
            if (skip_cnt == 3'd1) state <= IDLE;
         end else if (is_nonkey(byte_data)) begin
            state <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if (byte_data == PS2_EXT) begin
                     state <= EXT;
                  end else if (byte_data == PS2_BRK) begin
                     state <= BRK;
                  end else if (byte_data == PS2_PAUSE) begin
                     state    <= SKIP;
                     skip_cnt <= PAUSE_SKIP;
                  end
               end
               EXT: begin
                  if (byte_data == PS2_BRK)      state <= EXT_BRK;
                  else if (byte_data != PS2_EXT) state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

`ifdef PS2_TYPEMATIC_FILTER_EN
   logic [CODE_W:0] last_make;
   logic            last_valid;

   assign suppress_c = ev_pressed_c && last_valid && (last_make == {ev_ext_c, byte_data});

   // Remember the held key so auto-repeat makes do not re-strobe
   always_ff @(posedge clk) begin
      if (reset) begin
         last_make  <= '0;
         last_valid <= 1'b0;
      end else if (ev_req_c) begin
         if (ev_pressed_c) begin
            last_make  <= {ev_ext_c, byte_data};
            last_valid <= 1'b1;
         end else if (last_make == {ev_ext_c, byte_data}) begin
            last_valid <= 1'b0;
         end
      end
   end
`else
   assign suppress_c = 1'b0;
`endif

   // Event word: payload and toggle update together
   always_ff @(posedge clk) begin
      if (reset) begin
         key_q <= '0;
      end else if (ev_req_c && !suppress_c) begin
         key_q.toggle  <= ~key_q.toggle;
         key_q.pressed <= ev_pressed_c;
         key_q.ext     <= ev_ext_c;
         key_q.code    <= byte_data;
      end
   end

   assign ps2_key = key_q;

   // Saturating error counter
   always_ff @(posedge clk) begin
      if (reset) begin
         err_cnt <= '0;
      end else if (frame_err && (err_cnt != '1)) begin
         err_cnt <= err_cnt + ERR_W'(1);
      end
   end

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Directed scoreboard bench for ps2_key_encoder: frames are bit-banged on the PS/2 lines.
module tb_ps2_key_encoder;

   localparam int unsigned FILTER_LEN = 8;
   localparam logic [15:0] TIMEOUT    = 16'd6000;
   localparam int          HALF       = 20;
   localparam int          GAP        = 60;
   localparam int          OBS_MAX    = 64;
   // 2 sync stages + FILTER_LEN filter samples (stop bit taken on the last) + emit register
   localparam int          EVT_LAT    = FILTER_LEN + 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        ps2_clk;
   logic        ps2_data;
   logic [10:0] ps2_key;
   logic        frame_err;
   logic [7:0]  err_cnt;

   int checks   = 0;
   int failures = 0;

   logic [10:0] exp_q[$];
   logic        exp_tog = 1'b0;
   int          exp_total = 0;
   int          rd_idx = 0;
   int          stop_cyc = 0;

   int          cyc = 0;
   logic [10:0] obs_key[OBS_MAX];
   int          obs_cyc[OBS_MAX];
   int          obs_n = 0;
   int          fe_pulses = 0;
   int          fe_long = 0;
   logic        tog_prev = 1'b0;
   logic        fe_prev = 1'b0;

   ps2_key_encoder #(
      .FILTER_LEN (FILTER_LEN),
      .TIMEOUT    (TIMEOUT)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .ps2_key   (ps2_key),
      .frame_err (frame_err),
      .err_cnt   (err_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Record every toggle of ps2_key[10] and every frame_err cycle
   always @(negedge clk) begin
      if (reset) begin
         tog_prev <= 1'b0;
         fe_prev  <= 1'b0;
      end else begin
         if (ps2_key[10] !== tog_prev) begin
            if (obs_n < OBS_MAX) begin
               obs_key[obs_n] <= ps2_key;
               obs_cyc[obs_n] <= cyc;
            end
            obs_n    <= obs_n + 1;
            tog_prev <= ps2_key[10];
         end
         if (frame_err) begin
            fe_pulses <= fe_pulses + 1;
            if (fe_prev) fe_long <= fe_long + 1;
         end
         fe_prev <= frame_err;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_event(input logic pressed, input logic ext, input logic [7:0] code);
      exp_tog = ~exp_tog;
      exp_q.push_back({exp_tog, pressed, ext, code});
      exp_total++;
   endtask

   // Bit-bang one frame; glitch_at injects a 2-cycle low pulse while the clock is high
   task automatic send_frame(input logic [7:0] b, input bit bad_par, input int glitch_at,
                             input int nbits);
      logic [10:0] bits;
      bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         ps2_data = bits[i];
         wait_cyc(HALF);
         if (i == glitch_at) begin
            ps2_clk = 1'b0;
            wait_cyc(2);
            ps2_clk = 1'b1;
            wait_cyc(HALF);
         end
         ps2_clk = 1'b0;
         if (i == 10) stop_cyc = cyc;
         wait_cyc(HALF);
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
      wait_cyc(GAP);
   endtask

   // Pop the scoreboard for every newly observed event
   task automatic drain();
      logic [10:0] want;
      while (rd_idx < obs_n && rd_idx < OBS_MAX) begin
         chk("event_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            want = exp_q.pop_front();
            chk("ps2_key", 32'(obs_key[rd_idx]), 32'(want));
            chk("event_latency", 32'(obs_cyc[rd_idx] - stop_cyc), 32'(EVT_LAT));
         end
         rd_idx++;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      send_frame(b, 1'b0, -1, 11);
      drain();
   endtask

   initial begin
      int base;
      reset    = 1'b1;
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      wait_cyc(5);
      reset = 1'b0;
      wait_cyc(2);
      chk("reset_ps2_key", 32'(ps2_key), 32'h0);
      chk("reset_frame_err", 32'(frame_err), 32'h0);
      chk("reset_err_cnt", 32'(err_cnt), 32'h0);

      // Make and break
      expect_event(1'b1, 1'b0, 8'h1C);
      send_byte(8'h1C);
      send_byte(8'hF0);
      expect_event(1'b0, 1'b0, 8'h1C);
      send_byte(8'h1C);
      chk("make_break_toggles", 32'(obs_n), 32'd2);

      // Extended make and break
      send_byte(8'hE0);
      expect_event(1'b1, 1'b1, 8'h75);
      send_byte(8'h75);
      send_byte(8'hE0);
      send_byte(8'hF0);
      expect_event(1'b0, 1'b1, 8'h75);
      send_byte(8'h75);
      chk("ext_toggles", 32'(obs_n), 32'd4);

      // Parity error, then recovery
      send_frame(8'h1C, 1'b1, -1, 11);
      drain();
      chk("parity_err_pulses", 32'(fe_pulses), 32'd1);
      chk("parity_err_cnt", 32'(err_cnt), 32'd1);
      chk("parity_no_event", 32'(obs_n), 32'd4);
      expect_event(1'b1, 1'b0, 8'h1C);
      send_byte(8'h1C);

      // Partial frame left to time out
      send_frame(8'h55, 1'b0, -1, 5);
      wait_cyc(int'(TIMEOUT) + 10);
      chk("timeout_err_pulses", 32'(fe_pulses), 32'd2);
      chk("timeout_err_cnt", 32'(err_cnt), 32'd2);
      expect_event(1'b1, 1'b0, 8'h29);
      send_byte(8'h29);

      // Pause sequence, a non-key byte and a clock glitch
      base = obs_n;
      send_byte(8'hE1);
      send_frame(8'h14, 1'b0, 4, 11);
      drain();
      send_byte(8'h77);
      send_byte(8'hE1);
      send_byte(8'hF0);
      send_byte(8'h14);
      send_byte(8'hF0);
      send_byte(8'h77);
      send_byte(8'hFA);
      chk("pause_no_event", 32'(obs_n - base), 32'd0);
      expect_event(1'b1, 1'b0, 8'h16);
      send_byte(8'h16);
      chk("pause_glitch_err", 32'(fe_pulses), 32'd2);

      // Typematic repeats
      base = obs_n;
      expect_event(1'b1, 1'b0, 8'h1C);
      send_byte(8'h1C);
`ifndef PS2_TYPEMATIC_FILTER_EN
      expect_event(1'b1, 1'b0, 8'h1C);
`endif
      send_byte(8'h1C);
`ifndef PS2_TYPEMATIC_FILTER_EN
      expect_event(1'b1, 1'b0, 8'h1C);
`endif
      send_byte(8'h1C);
      send_byte(8'hF0);
      expect_event(1'b0, 1'b0, 8'h1C);
      send_byte(8'h1C);
      expect_event(1'b1, 1'b0, 8'h1C);
      send_byte(8'h1C);
`ifdef PS2_TYPEMATIC_FILTER_EN
      chk("typematic_toggles", 32'(obs_n - base), 32'd3);
`else
      chk("typematic_toggles", 32'(obs_n - base), 32'd5);
`endif

      wait_cyc(50);
      drain();
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      chk("total_events", 32'(obs_n), 32'(exp_total));
      chk("frame_err_width", 32'(fe_long), 32'd0);
      chk("final_err_cnt", 32'(err_cnt), 32'd2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
